// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands (unsigned otherwise).
module seq_restoring_divider #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] sq_q, sq_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
`ifdef DIV_SIGNED_EN
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
`endif

    logic [WIDTH:0]   sub_a, sub_b, sub_t;
    logic             cy;
    logic             nonneg;
    logic [WIDTH-1:0] r_iter, q_iter;
    logic [WIDTH-1:0] quot_fin, rem_fin;
    logic [WIDTH-1:0] a_mag, b_mag;

    // Trial subtraction as an explicit ripple-carry add of ~{0,D} with carry-in 1
    always_comb begin
        sub_a = {r_q, sq_q[WIDTH-1]};
        sub_b = ~{1'b0, d_q};
        sub_t = '0;
        cy    = 1'b1;
        for (int i = 0; i <= WIDTH; i++) begin
            sub_t[i] = sub_a[i] ^ sub_b[i] ^ cy;
            cy       = (sub_a[i] & sub_b[i]) | (cy & (sub_a[i] ^ sub_b[i]));
        end
        nonneg = cy;
    end

    always_comb begin
        r_iter = nonneg ? sub_t[WIDTH-1:0]
                        : {r_q[WIDTH-2:0], sq_q[WIDTH-1]};
        q_iter = {sq_q[WIDTH-2:0], nonneg};
`ifdef DIV_SIGNED_EN
        a_mag    = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
        b_mag    = divisor[WIDTH-1] ? (~divisor + 1'b1) : divisor;
        quot_fin = negq_q ? (~q_iter + 1'b1) : q_iter;
        rem_fin  = negr_q ? (~r_iter + 1'b1) : r_iter;
`else
        a_mag    = dividend;
        b_mag    = divisor;
        quot_fin = q_iter;
        rem_fin  = r_iter;
`endif
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        r_d     = r_q;
        sq_d    = sq_q;
        d_d     = d_q;
        dz_d    = dz_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
`ifdef DIV_SIGNED_EN
        negq_d  = negq_q;
        negr_d  = negr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d  = 1'b1;
                    dbz_d   = 1'b0;
                    quot_d  = '0;
                    rem_d   = '0;
                    r_d     = '0;
                    d_d     = b_mag;
                    count_d = CNT_W'(WIDTH);
`ifdef DIV_SIGNED_EN
                    negq_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    negr_d  = dividend[WIDTH-1];
`endif
                    // Zero divisor keeps the raw dividend for the remainder
                    if (divisor == '0) begin
                        sq_d    = dividend;
                        dz_d    = 1'b1;
                        state_d = FINISH;
                    end else begin
                        sq_d    = a_mag;
                        dz_d    = 1'b0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                r_d     = r_iter;
                sq_d    = q_iter;
                count_d = count_q - 1'b1;
                if (count_q == CNT_W'(1)) begin
                    quot_d  = quot_fin;
                    rem_d   = rem_fin;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = FINISH;
                end
            end
            FINISH: begin
                if (dz_q) begin
                    dz_d   = 1'b0;
                    done_d = 1'b1;
                    dbz_d  = 1'b1;
                    busy_d = 1'b0;
                    quot_d = '1;
                    rem_d  = sq_q;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            r_q     <= '0;
            sq_q    <= '0;
            d_q     <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
`ifdef DIV_SIGNED_EN
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            r_q     <= r_d;
            sq_q    <= sq_d;
            d_q     <= d_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
`ifdef DIV_SIGNED_EN
            negq_q  <= negq_d;
            negr_q  <= negr_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
